// File: rtl/cmd_slice_pkg.sv
// Shared op and state encodings for the command slice bank.
// ST_CLEAR only exists when CMD_SLICE_BANK_CLEAR_EN is defined.
package cmd_slice_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_SHIFT = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
`ifdef CMD_SLICE_BANK_CLEAR_EN
        ST_CLEAR = 3'd4,
`endif
        ST_DONE  = 3'd3
    } state_e;

endpackage

// File: rtl/cmd_slice_bank.sv
// Bank of DEPTH command entries updated by LOAD / SHIFT / CLEAR requests.
// The CLEAR op is built only when CMD_SLICE_BANK_CLEAR_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | ready for a request; illegal requests pulse err here
// ST_LOAD  | copy up to LANES entries per cycle from latched source
// ST_SHIFT | one-cycle copy of [base, base+len) to [base+len, base+2len)
// ST_CLEAR | one-cycle zero of [base, base+len)
// ST_DONE  | one-cycle done pulse, then back to ST_IDLE
module cmd_slice_bank
    import cmd_slice_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 9,
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         use_AnB,
    input  logic [WIDTH-1:0]             command_A [DEPTH-1:0],
    input  logic [WIDTH-1:0]             command_B [DEPTH-1:0],
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [$clog2(DEPTH+1)-1:0]   req_base,
    input  logic [$clog2(DEPTH+1)-1:0]   req_len,
    output logic [WIDTH-1:0]             active_command [DEPTH-1:0],
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int AW = $clog2(DEPTH + 1);
    // Two extra bits so base + 2*len never wraps during the legality check.
    localparam int XW = AW + 2;
    localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);
    localparam logic [XW-1:0] LANES_X = XW'(LANES);

    state_e           state;
    state_e           op_state;
    op_e              op;
    logic [XW-1:0]    cur_q;
    logic [XW-1:0]    rem_q;
    logic             use_a_q;
    logic             err_q;
    logic [XW-1:0]    base_x;
    logic [XW-1:0]    len_x;
    logic [XW-1:0]    chunk;
    logic             illegal;
    logic [WIDTH-1:0] bank_nxt [DEPTH-1:0];

    assign base_x = XW'(req_base);
    assign len_x  = XW'(req_len);
    assign op     = op_e'(req_op);
    assign chunk  = (rem_q < LANES_X) ? rem_q : LANES_X;

    always_comb begin
        illegal  = 1'b1;
        op_state = ST_IDLE;
        case (op)
            OP_LOAD: begin
                illegal  = (base_x + len_x) > DEPTH_X;
                op_state = ST_LOAD;
            end
            OP_SHIFT: begin
                illegal  = (base_x + len_x + len_x) > DEPTH_X;
                op_state = ST_SHIFT;
            end
`ifdef CMD_SLICE_BANK_CLEAR_EN
            OP_CLEAR: begin
                illegal  = (base_x + len_x) > DEPTH_X;
                op_state = ST_CLEAR;
            end
`endif
            default: ;
        endcase
        if (len_x == '0)
            illegal = 1'b1;
    end

    // cur_q/rem_q double as base/len for SHIFT and CLEAR.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            bank_nxt[j] = active_command[j];
            case (state)
                ST_LOAD: begin
                    if (XW'(j) >= cur_q && XW'(j) < cur_q + chunk)
                        bank_nxt[j] = use_a_q ? command_A[j] : command_B[j];
                end
                ST_SHIFT: begin
                    if (XW'(j) >= cur_q + rem_q && XW'(j) < cur_q + rem_q + rem_q) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (XW'(k) + rem_q == XW'(j))
                                bank_nxt[j] = active_command[k];
                        end
                    end
                end
`ifdef CMD_SLICE_BANK_CLEAR_EN
                ST_CLEAR: begin
                    if (XW'(j) >= cur_q && XW'(j) < cur_q + rem_q)
                        bank_nxt[j] = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            use_a_q <= 1'b0;
            err_q   <= 1'b0;
            for (int j = 0; j < DEPTH; j++)
                active_command[j] <= '0;
        end else begin
            err_q <= 1'b0;
            for (int j = 0; j < DEPTH; j++)
                active_command[j] <= bank_nxt[j];
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            state   <= op_state;
                            cur_q   <= base_x;
                            rem_q   <= len_x;
                            use_a_q <= use_AnB;
                        end
                    end
                end
                ST_LOAD: begin
                    cur_q <= cur_q + chunk;
                    rem_q <= rem_q - chunk;
                    if (rem_q <= LANES_X)
                        state <= ST_DONE;
                end
                ST_SHIFT: state <= ST_DONE;
`ifdef CMD_SLICE_BANK_CLEAR_EN
                ST_CLEAR: state <= ST_DONE;
`endif
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_cmd_slice_bank.sv
// Directed plus randomized bench for cmd_slice_bank against an array model.
// Honours CMD_SLICE_BANK_CLEAR_EN when deciding whether CLEAR is legal.
module tb_cmd_slice_bank;

    localparam int WIDTH = 2;
    localparam int DEPTH = 9;
    localparam int LANES = 4;
    localparam int AW    = $clog2(DEPTH + 1);

`ifdef CMD_SLICE_BANK_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             use_AnB = 1'b0;
    logic [WIDTH-1:0] command_A [DEPTH-1:0];
    logic [WIDTH-1:0] command_B [DEPTH-1:0];
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'd0;
    logic [AW-1:0]    req_base = '0;
    logic [AW-1:0]    req_len = '0;
    logic [WIDTH-1:0] active_command [DEPTH-1:0];
    logic             busy;
    logic             done;
    logic             err;

    int n_assert = 0;
    int n_fail   = 0;
    int model [DEPTH];
    int src_a [DEPTH];
    int src_b [DEPTH];

    cmd_slice_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk            (clk),
        .rst            (rst),
        .use_AnB        (use_AnB),
        .command_A      (command_A),
        .command_B      (command_B),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_base       (req_base),
        .req_len        (req_len),
        .active_command (active_command),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int j = 0; j < DEPTH; j++)
            check($sformatf("%s[%0d]", tag, j), 32'(active_command[j]), 32'(model[j]));
    endtask

    task automatic set_sources();
        for (int j = 0; j < DEPTH; j++) begin
            command_A[j] = WIDTH'(src_a[j]);
            command_B[j] = WIDTH'(src_b[j]);
        end
    endtask

    function automatic bit is_legal(input int op, input int base, input int len);
        if (len == 0) return 1'b0;
        case (op)
            0: return base + len <= DEPTH;
            1: return base + 2 * len <= DEPTH;
            2: return CLEAR_EN && (base + len <= DEPTH);
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply_model(input int op, input int base, input int len, input bit use_a);
        int old [DEPTH];
        old = model;
        case (op)
            0: for (int i = 0; i < len; i++) model[base + i] = use_a ? src_a[base + i] : src_b[base + i];
            1: for (int i = 0; i < len; i++) model[base + len + i] = old[base + i];
            2: for (int i = 0; i < len; i++) model[base + i] = 0;
            default: ;
        endcase
    endtask

    // Issues one request, checks handshake timing cycle by cycle, then the bank.
    task automatic run_req(input int op, input int base, input int len, input bit use_a, input string tag);
        bit legal;
        int op_cycles;
        legal = is_legal(op, base, len);
        @(negedge clk);
        check({tag, ".ready_pre"}, 32'(req_ready), 32'd1);
        req_op    = 2'(op);
        req_base  = AW'(base);
        req_len   = AW'(len);
        use_AnB   = use_a;
        req_valid = 1'b1;
        @(negedge clk);
        if (!legal) begin
            req_valid = 1'b0;
            check({tag, ".err"}, 32'(err), 32'd1);
            check({tag, ".done_ill"}, 32'(done), 32'd0);
            check({tag, ".ready_ill"}, 32'(req_ready), 32'd1);
            @(negedge clk);
            check({tag, ".err_end"}, 32'(err), 32'd0);
            check_bank({tag, ".bank"});
            return;
        end
        op_cycles = (op == 0) ? (len + LANES - 1) / LANES : 1;
        for (int k = 0; k <= op_cycles; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("%s.done_c%0d", tag, k), 32'(done), 32'(k == op_cycles));
            check($sformatf("%s.err_c%0d", tag, k), 32'(err), 32'd0);
            check($sformatf("%s.busy_c%0d", tag, k), 32'(busy), 32'd1);
            check($sformatf("%s.ready_c%0d", tag, k), 32'(req_ready), 32'd0);
            if (k < op_cycles) begin
                req_valid = 1'($urandom_range(0, 1));
                req_op    = 2'($urandom_range(0, 3));
                req_base  = AW'($urandom_range(0, 9));
                req_len   = AW'($urandom_range(0, 9));
                use_AnB   = 1'($urandom_range(0, 1));
            end else begin
                req_valid = 1'b0;
            end
        end
        apply_model(op, base, len, use_a);
        @(negedge clk);
        check({tag, ".done_end"}, 32'(done), 32'd0);
        check({tag, ".ready_end"}, 32'(req_ready), 32'd1);
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        check_bank({tag, ".bank"});
    endtask

    initial begin
        for (int j = 0; j < DEPTH; j++) begin
            src_a[j] = 0;
            src_b[j] = 0;
            model[j] = 0;
        end
        set_sources();

        // Reset for two cycles
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check_bank("rst.bank");
        rst = 1'b0;

        // Directed LOAD of A[i] = i % 4
        for (int j = 0; j < DEPTH; j++) begin
            src_a[j] = j % 4;
            src_b[j] = $urandom_range(0, 3);
        end
        set_sources();
        run_req(0, 0, 8, 1'b1, "load8");
        run_req(1, 0, 4, 1'b0, "shift4");
        run_req(0, 6, 4, 1'b1, "load_oob");
        run_req(2, 2, 3, 1'b0, "clear3");
        run_req(3, 0, 1, 1'b0, "op_rsvd");
        run_req(0, 3, 0, 1'b0, "len0");
        run_req(1, 1, 4, 1'b0, "shift_edge");
        run_req(1, 2, 4, 1'b0, "shift_oob");
        run_req(0, 8, 1, 1'b0, "load_last");

        // Reset in the second LOAD cycle of a full-length load
        for (int j = 0; j < DEPTH; j++) src_a[j] = $urandom_range(1, 3);
        set_sources();
        @(negedge clk);
        req_op = 2'd0; req_base = '0; req_len = AW'(9); use_AnB = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < DEPTH; j++) model[j] = 0;
        check("midrst.ready", 32'(req_ready), 32'd1);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check_bank("midrst.bank");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst.done_after%0d", k), 32'(done), 32'd0);
            check($sformatf("midrst.err_after%0d", k), 32'(err), 32'd0);
        end

        // Randomized requests
        for (int n = 0; n < 60; n++) begin
            int op, base, len;
            for (int j = 0; j < DEPTH; j++) begin
                src_a[j] = $urandom_range(0, 3);
                src_b[j] = $urandom_range(0, 3);
            end
            set_sources();
            op   = $urandom_range(0, 3);
            base = $urandom_range(0, 9);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 4);
            run_req(op, base, len, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
